// File: rtl/cache_ctrl_if.sv
// Bundle of CPU, cache-set and memory signals around the single-set cache controller.
// master = controller side, slave = CPU/set/memory side.
interface cache_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [6:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_busy;

  logic        enable;
  logic        comp;
  logic        write;
  logic [1:0]  word;
  logic [4:0]  tag_in;
  logic [15:0] data_in;
  logic        valid_in;
  logic        hit;
  logic        dirty_out;
  logic        valid_out;
  logic        ack;
  logic [4:0]  tag_out;
  logic [15:0] data_out;

  logic        mem_req;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready, cpu_busy,
    output enable, comp, write, word, tag_in, data_in, valid_in,
    input  hit, dirty_out, valid_out, ack, tag_out, data_out,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready, cpu_busy,
    input  enable, comp, write, word, tag_in, data_in, valid_in,
    output hit, dirty_out, valid_out, ack, tag_out, data_out,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/cache_ctrl.sv
// Single-set cache controller: compare, dirty write-back, write-allocate refill, retry.
// Optional CACHE_CTRL_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
//
// state  | meaning
// IDLE   | waiting for cpu_req
// CMP    | compare access to the set, waiting for ack
// WB_RD  | direct read of victim word, waiting for ack
// WB_MEM | writing victim word to memory, waiting for mem_ack
// RF_MEM | reading refill word from memory, waiting for mem_ack
// RF_WR  | direct write of refill word into the set, waiting for ack
// GAP    | one idle cycle between transactions, then launch ret_state
// DONE   | cpu_ready pulse
module cache_ctrl (
  input  logic         clk,
  input  logic         rst,
  cache_ctrl_if.master bus
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [15:0]  hit_cnt,
  output logic [15:0]  miss_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE, CMP, WB_RD, WB_MEM, RF_MEM, RF_WR, GAP, DONE
  } state_t;

  state_t      state;
  state_t      ret_state;
  logic        req_we;
  logic [4:0]  req_tag;
  logic [1:0]  req_word;
  logic [15:0] req_wdata;
  logic [1:0]  cnt;
  logic [4:0]  wb_tag;
  logic [15:0] xfer_data;
  logic        retry;
  logic        real_hit;

  assign real_hit = bus.hit && bus.valid_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      ret_state     <= IDLE;
      req_we        <= 1'b0;
      req_tag       <= '0;
      req_word      <= '0;
      req_wdata     <= '0;
      cnt           <= '0;
      wb_tag        <= '0;
      xfer_data     <= '0;
      retry         <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.cpu_ready <= 1'b0;
      bus.cpu_busy  <= 1'b0;
      bus.enable    <= 1'b0;
      bus.comp      <= 1'b0;
      bus.write     <= 1'b0;
      bus.word      <= '0;
      bus.tag_in    <= '0;
      bus.data_in   <= '0;
      bus.valid_in  <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
`ifdef CACHE_CTRL_STATS_EN
      hit_cnt       <= '0;
      miss_cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            req_we       <= bus.cpu_we;
            req_tag      <= bus.cpu_addr[6:2];
            req_word     <= bus.cpu_addr[1:0];
            req_wdata    <= bus.cpu_wdata;
            retry        <= 1'b0;
            bus.cpu_busy <= 1'b1;
            // Launch the compare straight away to keep hit latency minimal
            bus.enable   <= 1'b1;
            bus.comp     <= 1'b1;
            bus.write    <= bus.cpu_we;
            bus.word     <= bus.cpu_addr[1:0];
            bus.tag_in   <= bus.cpu_addr[6:2];
            bus.data_in  <= bus.cpu_wdata;
            bus.valid_in <= 1'b0;
            state        <= CMP;
          end
        end

        CMP: begin
          if (bus.ack) begin
            bus.enable <= 1'b0;
            cnt        <= '0;
            state      <= GAP;
            if (real_hit) begin
              if (!req_we) bus.cpu_rdata <= bus.data_out;
              ret_state <= DONE;
            end else if (bus.valid_out && bus.dirty_out) begin
              ret_state <= WB_RD;
            end else begin
              ret_state <= RF_MEM;
            end
`ifdef CACHE_CTRL_STATS_EN
            if (!retry) begin
              if (real_hit) begin
                if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
              end else begin
                if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
              end
            end
`endif
          end
        end

        WB_RD: begin
          if (bus.ack) begin
            bus.enable <= 1'b0;
            wb_tag     <= bus.tag_out;
            xfer_data  <= bus.data_out;
            ret_state  <= WB_MEM;
            state      <= GAP;
          end
        end

        WB_MEM: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            cnt         <= cnt + 2'd1;
            ret_state   <= (cnt == 2'd3) ? RF_MEM : WB_RD;
            state       <= GAP;
          end
        end

        RF_MEM: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            xfer_data   <= bus.mem_rdata;
            ret_state   <= RF_WR;
            state       <= GAP;
          end
        end

        RF_WR: begin
          if (bus.ack) begin
            bus.enable <= 1'b0;
            cnt        <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              retry     <= 1'b1;
              ret_state <= CMP;
            end else begin
              ret_state <= RF_MEM;
            end
            state <= GAP;
          end
        end

        // Idle cycle lets the set see a falling enable and memory see mem_req drop;
        // the next transaction's outputs are registered here so they appear with the state.
        GAP: begin
          state <= ret_state;
          case (ret_state)
            CMP: begin
              bus.enable   <= 1'b1;
              bus.comp     <= 1'b1;
              bus.write    <= req_we;
              bus.word     <= req_word;
              bus.tag_in   <= req_tag;
              bus.data_in  <= req_wdata;
              bus.valid_in <= 1'b0;
            end
            WB_RD: begin
              bus.enable   <= 1'b1;
              bus.comp     <= 1'b0;
              bus.write    <= 1'b0;
              bus.word     <= cnt;
              bus.valid_in <= 1'b0;
            end
            RF_WR: begin
              bus.enable   <= 1'b1;
              bus.comp     <= 1'b0;
              bus.write    <= 1'b1;
              bus.word     <= cnt;
              bus.tag_in   <= req_tag;
              bus.data_in  <= xfer_data;
              bus.valid_in <= 1'b1;
            end
            WB_MEM: begin
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= {wb_tag, cnt};
              bus.mem_wdata <= xfer_data;
            end
            RF_MEM: begin
              bus.mem_req  <= 1'b1;
              bus.mem_we   <= 1'b0;
              bus.mem_addr <= {req_tag, cnt};
            end
            DONE: begin
              bus.cpu_ready <= 1'b1;
            end
            default: begin
              state <= IDLE;
            end
          endcase
        end

        DONE: begin
          bus.cpu_ready <= 1'b0;
          bus.cpu_busy  <= 1'b0;
          state         <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized bench for cache_ctrl: behavioural set and memory responders plus a flat
// golden memory view; checks load data, memory traffic, hit latency and handshake hold.
module tb_cache_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_ctrl_if bus();

`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
  cache_ctrl dut (.clk(clk), .rst(rst), .bus(bus), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));
`else
  cache_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bit [15:0] mem    [128];
  bit [15:0] golden [128];
  bit        s_valid;
  bit        s_dirty;
  bit [4:0]  s_tag;
  bit [15:0] s_data [4];

  int set_lat = 0;
  int mem_lat = 0;
  int set_cnt = 0;
  int mem_cnt = 0;
  bit mem_done = 0;
  logic [31:0] set_snap;
  logic [23:0] mem_snap;
  logic [23:0] obs_q[$];
  logic [23:0] exp_q[$];
  int exp_hits = 0;
  int exp_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Cache-set behaviour: raw tag compare for hit, compare-write only on a valid match,
  // direct write installs tag/valid and leaves the block clean.
  task automatic set_access();
    bus.valid_out = s_valid;
    bus.dirty_out = s_dirty;
    bus.tag_out   = s_tag;
    bus.data_out  = s_data[bus.word];
    bus.hit       = 1'b0;
    if (bus.comp) begin
      bus.hit = (s_tag == bus.tag_in);
      if (bus.write && bus.hit && s_valid) begin
        s_data[bus.word] = bus.data_in;
        s_dirty = 1'b1;
      end
    end else if (bus.write) begin
      s_data[bus.word] = bus.data_in;
      s_tag   = bus.tag_in;
      s_valid = bus.valid_in;
      s_dirty = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!bus.enable) begin
      set_cnt = 0;
      bus.ack = 1'b0;
    end else if (!bus.ack) begin
      set_cnt++;
      if (set_cnt == 1)
        set_snap = {8'h0, bus.comp, bus.write, bus.word, bus.tag_in, bus.data_in, bus.valid_in};
      if (set_cnt == set_lat + 1) begin
        chk("set_hold", {8'h0, bus.comp, bus.write, bus.word, bus.tag_in, bus.data_in, bus.valid_in}, set_snap);
        set_access();
        bus.ack = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!bus.mem_req) begin
      mem_cnt = 0;
      mem_done = 1'b0;
      bus.mem_ack = 1'b0;
    end else if (bus.mem_ack) begin
      bus.mem_ack = 1'b0;
    end else if (!mem_done) begin
      mem_cnt++;
      if (mem_cnt == 1) mem_snap = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
      if (mem_cnt == mem_lat + 1) begin
        chk("mem_hold", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, mem_snap);
        if (bus.mem_we) begin
          mem[bus.mem_addr] = bus.mem_wdata;
          obs_q.push_back({1'b1, bus.mem_addr, bus.mem_wdata});
        end else begin
          bus.mem_rdata = mem[bus.mem_addr];
          obs_q.push_back({1'b0, bus.mem_addr, 16'h0});
        end
        bus.mem_ack = 1'b1;
        mem_done = 1'b1;
      end
    end
  end

  // Install a block directly into the set model, keeping golden/mem coherent.
  task automatic preload(input bit v, input bit d, input bit [4:0] t);
    bit [6:0] a;
    if (s_valid && s_dirty)
      for (int w = 0; w < 4; w++) begin
        a = {s_tag, w[1:0]};
        mem[a] = s_data[w];
      end
    s_valid = v;
    s_dirty = d;
    s_tag   = t;
    for (int w = 0; w < 4; w++) begin
      a = {t, w[1:0]};
      s_data[w] = 16'($urandom);
      if (v) golden[a] = s_data[w];
      if (v && !d) mem[a] = s_data[w];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_hits = 0;
    exp_miss = 0;
  endtask

  task automatic do_req(input bit we, input bit [6:0] addr, input bit [15:0] wd,
                        input int a_lat, input int m_lat, input bit poke, input string nm);
    bit [4:0]  t;
    bit        exp_hit;
    bit [15:0] exp_rd;
    bit [15:0] got_rd;
    int        lat;
    int        nready;
    int        n;
    t = addr[6:2];
    set_lat = a_lat;
    mem_lat = m_lat;
    exp_hit = s_valid && (s_tag == t);
    exp_q.delete();
    obs_q.delete();
    if (!exp_hit) begin
      if (s_valid && s_dirty)
        for (int w = 0; w < 4; w++) exp_q.push_back({1'b1, s_tag, w[1:0], s_data[w]});
      for (int w = 0; w < 4; w++) exp_q.push_back({1'b0, t, w[1:0], 16'h0});
    end
    exp_rd = golden[addr];
    if (we) golden[addr] = wd;
    if (exp_hit) exp_hits++;
    else exp_miss++;

    @(negedge clk);
    bus.cpu_req = 1'b1;
    bus.cpu_we = we;
    bus.cpu_addr = addr;
    bus.cpu_wdata = wd;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    lat = 1;
    chk({nm, ":busy"}, bus.cpu_busy, 1);
    while (!bus.cpu_ready && lat < 3000) begin
      bus.cpu_req = poke && (lat == 2);
      if (poke && lat == 2) begin
        bus.cpu_addr  = addr ^ 7'h7F;
        bus.cpu_we    = ~we;
        bus.cpu_wdata = ~wd;
      end
      @(negedge clk);
      lat++;
    end
    bus.cpu_req = 1'b0;
    chk({nm, ":ready"}, bus.cpu_ready, 1);
    got_rd = bus.cpu_rdata;
    nready = bus.cpu_ready ? 1 : 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.cpu_ready) nready++;
    end
    chk({nm, ":nready"}, nready, 1);
    chk({nm, ":idle"}, bus.cpu_busy, 0);
    if (!we) chk({nm, ":rdata"}, got_rd, exp_rd);
    if (exp_hit) chk({nm, ":lat"}, lat, a_lat + 3);
    chk({nm, ":ntraffic"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({nm, ":traffic"}, obs_q[i], exp_q[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [4:0] pool [4];
    bit [4:0] t;
    bit       found;
    bit [6:0] a;
    bit [15:0] v;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    bus.mem_rdata = '0;
    for (int i = 0; i < 128; i++) begin
      mem[i] = 16'($urandom);
      golden[i] = mem[i];
    end
    s_valid = 1'b0;
    s_dirty = 1'b0;
    s_tag = '0;
    for (int w = 0; w < 4; w++) s_data[w] = '0;

    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_ctl", {bus.enable, bus.comp, bus.write, bus.word, bus.tag_in, bus.valid_in,
                    bus.cpu_ready, bus.cpu_busy, bus.mem_req, bus.mem_we, bus.mem_addr}, 0);
    chk("rst_data_in", bus.data_in, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 0);
    @(negedge clk);
    rst = 1'b1;

    do_req(1'b0, 7'h25, 16'h0, 1, 1, 1'b0, "t1_cold");
    chk("t1_valid", s_valid, 1);
    chk("t1_tag", s_tag, 5'h09);
    chk("t1_dirty", s_dirty, 0);

    preload(1'b1, 1'b1, 5'h0A);
    s_data[2] = 16'hBEEF;
    golden[{5'h0A, 2'd2}] = 16'hBEEF;
    do_req(1'b0, {5'h0A, 2'd2}, 16'h0, 2, 1, 1'b0, "t2_hit");

    preload(1'b1, 1'b1, 5'h03);
    do_req(1'b1, {5'h12, 2'd3}, 16'h5A3C, 1, 2, 1'b0, "t3_wb");
    chk("t3_dirty", s_dirty, 1);
    chk("t3_word", s_data[3], 16'h5A3C);

    do_req(1'b0, {5'h12, 2'd0}, 16'h0, 1, 1, 1'b1, "t4_busy_hit");
    do_req(1'b1, {5'h07, 2'd1}, 16'h1234, 0, 1, 1'b1, "t4_busy_miss");

    preload(1'b1, 1'b1, 5'h11);
    set_lat = 1;
    mem_lat = 3;
    @(negedge clk);
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = {5'h02, 2'd1};
    @(negedge clk);
    bus.cpu_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(posedge clk);
      #1;
      if (bus.mem_req && bus.mem_we) found = 1'b1;
    end
    chk("t5_reach_wb", found, 1);
    rst = 1'b0;
    #1;
    chk("t5_enable", bus.enable, 0);
    chk("t5_mem_req", bus.mem_req, 0);
    chk("t5_busy", bus.cpu_busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_hits = 0;
    exp_miss = 0;
    do_req(1'b0, {5'h02, 2'd1}, 16'h0, 1, 1, 1'b0, "t5_after");

    pool[0] = 5'h03;
    pool[1] = 5'h09;
    pool[2] = 5'h11;
    for (int it = 0; it < 40; it++) begin
      pool[3] = 5'($urandom);
      t = pool[$urandom_range(0, 3)];
      if (it % 8 == 0) preload(1'b0, 1'b0, t);
      do_req(1'($urandom), {t, 2'($urandom)}, 16'($urandom), $urandom_range(0, 3),
             $urandom_range(0, 3), ($urandom_range(0, 4) == 0), "rnd");
    end

`ifdef CACHE_CTRL_STATS_EN
    chk("stats_hit_rnd", hit_cnt, exp_hits);
    chk("stats_miss_rnd", miss_cnt, exp_miss);
    do_reset();
    chk("stats_rst", {hit_cnt, miss_cnt}, 0);
    preload(1'b1, 1'b0, 5'h05);
    do_req(1'b0, {5'h05, 2'd0}, 16'h0, 1, 1, 1'b0, "st_h1");
    do_req(1'b1, {5'h05, 2'd1}, 16'hCAFE, 0, 1, 1'b0, "st_h2");
    do_req(1'b0, {5'h06, 2'd2}, 16'h0, 1, 0, 1'b0, "st_m1");
    do_req(1'b0, {5'h06, 2'd3}, 16'h0, 2, 1, 1'b0, "st_h3");
    do_req(1'b0, {5'h07, 2'd0}, 16'h0, 1, 1, 1'b0, "st_m2");
    chk("stats_hit", hit_cnt, 3);
    chk("stats_miss", miss_cnt, 2);
`endif

    for (int i = 0; i < 128; i++) begin
      a = 7'(i);
      v = (s_valid && s_tag == a[6:2]) ? s_data[a[1:0]] : mem[a];
      chk("coherence", v, golden[a]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
